// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the IF/MEM single-port SRAM arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_RESP
  } arb_state_e;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } arb_owner_e;

  localparam int unsigned ARB_ADDR_W = 14;
  localparam int unsigned ARB_DATA_W = 32;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and SRAM signal bundle for mem_port_arbiter; the slave modport is the arbiter side.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ARB_ADDR_W,
  parameter int unsigned DATA_W = ARB_DATA_W
);
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic [DATA_W-1:0]     if_rdata;
  logic                  if_done;
  logic                  if_stall;

  logic                  dm_req;
  logic [DATA_W/8-1:0]   dm_we;
  logic [ADDR_W-1:0]     dm_addr;
  logic [DATA_W-1:0]     dm_wdata;
  logic [DATA_W-1:0]     dm_rdata;
  logic                  dm_done;
  logic                  dm_stall;

  logic                  mem_cs;
  logic [DATA_W/8-1:0]   mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_di;
  logic [DATA_W-1:0]     mem_do;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_do,
    output if_rdata, if_done, if_stall, dm_rdata, dm_done, dm_stall,
           mem_cs, mem_we, mem_addr, mem_di
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_do,
    input  if_rdata, if_done, if_stall, dm_rdata, dm_done, dm_stall,
           mem_cs, mem_we, mem_addr, mem_di
  );
endinterface

// File: rtl/mem_port_arbiter_lat_counter.sv
// Read-latency counter: loaded with MEM_LAT on issue, counts down in WAIT, flags the last cycle.
module arb_lat_counter #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic last
);
  localparam int unsigned CW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= CW'(MEM_LAT);
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign last = (cnt_q == CW'(1));
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between fetch (IF) and load/store (DM) via an issue/wait/response FSM.
// Optional starvation guard for IF is enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = ARB_ADDR_W,
  parameter int unsigned DATA_W     = ARB_DATA_W,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned BE_W = DATA_W / 8;

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q;
  logic              abort_q;
  logic              abort_now;
  logic              flush_now;
  logic              any_req;
  logic              grant_dm;
  logic              lat_last;
  logic [ADDR_W-1:0] addr_q;
  logic [BE_W-1:0]   we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;

  assign any_req   = bus.if_req | bus.dm_req;
  // A fetch withdrawn mid-access still finishes on the SRAM but must not complete.
  assign flush_now = (owner_q == OWN_IF) && (state_q != ARB_IDLE) && !bus.if_req;
  assign abort_now = abort_q | flush_now;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (state_q == ARB_IDLE) begin
      if (!bus.if_req) begin
        starve_cnt <= '0;
      end else if (grant_dm) begin
        starve_cnt <= starve_cnt + SW'(1);
      end else begin
        starve_cnt <= '0;
      end
    end
  end

  assign grant_dm = bus.dm_req && !(bus.if_req && (starve_cnt == SW'(STARVE_MAX)));
`else
  assign grant_dm = bus.dm_req;
`endif

  arb_lat_counter #(
    .MEM_LAT (MEM_LAT)
  ) u_lat (
    .clk  (clk),
    .rst  (rst),
    .load (state_q == ARB_ISSUE),
    .en   (state_q == ARB_WAIT),
    .last (lat_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE:  if (any_req) state_d = ARB_ISSUE;
      ARB_ISSUE: state_d = (we_q != '0) ? ARB_RESP : ARB_WAIT;
      ARB_WAIT:  if (lat_last) state_d = ARB_RESP;
      ARB_RESP:  state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_cs   = (state_q == ARB_ISSUE);
    bus.mem_we   = (state_q == ARB_ISSUE) ? we_q : '0;
    bus.mem_addr = addr_q;
    bus.mem_di   = wdata_q;
    bus.if_done  = !rst && (state_q == ARB_RESP) && (owner_q == OWN_IF) && !abort_now;
    bus.dm_done  = !rst && (state_q == ARB_RESP) && (owner_q == OWN_DM);
    bus.if_stall = bus.if_req && !bus.if_done;
    bus.dm_stall = bus.dm_req && !bus.dm_done;
    bus.if_rdata = if_rdata_q;
    bus.dm_rdata = dm_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q    <= OWN_IF;
      abort_q    <= 1'b0;
      addr_q     <= '0;
      we_q       <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      if ((state_q == ARB_IDLE) && any_req) begin
        owner_q <= grant_dm ? OWN_DM : OWN_IF;
        addr_q  <= grant_dm ? bus.dm_addr : bus.if_addr;
        we_q    <= grant_dm ? bus.dm_we : '0;
        wdata_q <= grant_dm ? bus.dm_wdata : '0;
      end
      if (state_q == ARB_RESP) begin
        abort_q <= 1'b0;
      end else if (flush_now) begin
        abort_q <= 1'b1;
      end
      if ((state_q == ARB_WAIT) && lat_last) begin
        if (owner_q == OWN_DM) begin
          dm_rdata_q <= bus.mem_do;
        end else if (!abort_now) begin
          if_rdata_q <= bus.mem_do;
        end
      end
    end
  end

  a_params_ok: assert property (@(posedge clk) (MEM_LAT >= 1) && (STARVE_MAX >= 1));

  a_dm_req_held: assert property (@(posedge clk) disable iff (rst)
    (bus.dm_req && !bus.dm_done) |=> bus.dm_req);
endmodule
